// File: rtl/accumulator_bank_if.sv
// -----------------------------------------------------------------------------
// accumulator_bank_if
// Bundles the request, direct-write, read and status signals of
// accumulator_bank. The master modport drives requests, writes and read
// selects; the slave modport (the bank) drives grants, read data and status.
//
// Signals:
//   req_valid [N_REQ][N_ACC]          add request, requester r -> accumulator a
//   req_data  [N_REQ][N_ACC]x DW      addend for that request
//   req_ready [N_REQ][N_ACC]          grant (accepted when valid & ready)
//   wr_en / wr_sel / wr_data          direct overwrite of one accumulator
//   wr_ready                          selected accumulator has nothing in flight
//   rd_sel / rd_data                  combinational read of committed value
//   all_ready / no_req / idle         bank-wide status
// -----------------------------------------------------------------------------
interface accumulator_bank_if #(
  parameter int N_REQ      = 4,
  parameter int N_ACC      = 3,
  parameter int DATA_WIDTH = 32
);
  localparam int SEL_W = (N_ACC > 1) ? $clog2(N_ACC) : 1;

  logic [N_REQ-1:0][N_ACC-1:0]                 req_valid;
  logic [N_REQ-1:0][N_ACC-1:0][DATA_WIDTH-1:0] req_data;
  logic [N_REQ-1:0][N_ACC-1:0]                 req_ready;
  logic                                        wr_en;
  logic [SEL_W-1:0]                            wr_sel;
  logic [DATA_WIDTH-1:0]                       wr_data;
  logic                                        wr_ready;
  logic [SEL_W-1:0]                            rd_sel;
  logic [DATA_WIDTH-1:0]                       rd_data;
  logic                                        all_ready;
  logic                                        no_req;
  logic                                        idle;

  modport master (
    output req_valid, req_data, wr_en, wr_sel, wr_data, rd_sel,
    input  req_ready, wr_ready, rd_data, all_ready, no_req, idle
  );

  modport slave (
    input  req_valid, req_data, wr_en, wr_sel, wr_data, rd_sel,
    output req_ready, wr_ready, rd_data, all_ready, no_req, idle
  );
endinterface

// File: rtl/accumulator_bank.sv
// -----------------------------------------------------------------------------
// accumulator_bank
// N_ACC independent accumulators, each shared by N_REQ requesters through a
// round-robin arbiter. An accepted add completes LATENCY cycles after its
// dispatch edge; a new add may be dispatched on the very edge the previous one
// retires, using the retiring result as its operand (bypass). A direct write
// can overwrite an accumulator that has nothing in flight and wins over a
// dispatch to the same accumulator in the same cycle.
//
// Ports:
//   i_clk    clock, rising edge
//   i_reset  synchronous active-high reset
//   bus      accumulator_bank_if.slave (requests, write, read, status)
// -----------------------------------------------------------------------------
module accumulator_bank #(
  parameter int N_REQ      = 4,
  parameter int N_ACC      = 3,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 6
) (
  input  logic              i_clk,
  input  logic              i_reset,
  accumulator_bank_if.slave bus
);
  localparam int SEL_W = (N_ACC > 1) ? $clog2(N_ACC) : 1;
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(LATENCY) + 1;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // State per accumulator. r_pend holds the sum of the add in flight; it is
  // committed into r_acc on the edge where the countdown reaches zero, which
  // is exactly LATENCY edges after dispatch.
  logic [DATA_WIDTH-1:0] r_acc  [N_ACC];
  logic [DATA_WIDTH-1:0] r_pend [N_ACC];
  logic [CNT_W-1:0]      r_cnt  [N_ACC];
  logic [PTR_W-1:0]      r_ptr  [N_ACC];

  logic [N_ACC-1:0]      w_wr_hit;
  logic [N_ACC-1:0]      w_can_accept;
  logic [N_ACC-1:0]      w_fire;
  logic [N_ACC-1:0]      w_cnt_le1;
  logic [N_ACC-1:0]      w_cnt_zero;
  logic [PTR_W-1:0]      w_grant_idx [N_ACC];
  logic [DATA_WIDTH-1:0] w_sum       [N_ACC];
  logic                  w_wr_sel_ok;
  logic                  w_rd_sel_ok;

  // Requester index 'offset' places after 'base', wrapped modulo N_REQ.
  function automatic int rr_index(input int base, input int offset);
    int k;
    k = base + offset;
    if (k >= N_REQ) k = k - N_REQ;
    return k;
  endfunction

  assign w_wr_sel_ok = (int'(bus.wr_sel) < N_ACC);
  assign w_rd_sel_ok = (int'(bus.rd_sel) < N_ACC);

  genvar gi, gr;
  generate
    for (gi = 0; gi < N_ACC; gi++) begin : g_acc
      logic                  w_found;
      logic [PTR_W-1:0]      w_idx;
      logic [DATA_WIDTH-1:0] w_opa;

      assign w_cnt_zero[gi] = (r_cnt[gi] == '0);
      assign w_cnt_le1[gi]  = (r_cnt[gi] <= CNT_ONE);

      // A write only fires on an idle accumulator; when it fires it takes
      // the slot and the arbiter sees no capacity this cycle.
      assign w_wr_hit[gi]     = bus.wr_en && w_wr_sel_ok &&
                                (int'(bus.wr_sel) == gi) && w_cnt_zero[gi];
      assign w_can_accept[gi] = w_cnt_le1[gi] && !w_wr_hit[gi];

      // First valid requester at or after the round-robin pointer.
      always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int o = 0; o < N_REQ; o++) begin
          if (!w_found && bus.req_valid[rr_index(int'(r_ptr[gi]), o)][gi]) begin
            w_found = 1'b1;
            w_idx   = PTR_W'(rr_index(int'(r_ptr[gi]), o));
          end
        end
      end

      assign w_fire[gi]      = w_found && w_can_accept[gi];
      assign w_grant_idx[gi] = w_idx;

      // count==1 means the in-flight result retires on this same edge, so it
      // is the up-to-date operand rather than the committed value.
      assign w_opa     = (r_cnt[gi] == CNT_ONE) ? r_pend[gi] : r_acc[gi];
      assign w_sum[gi] = w_opa + bus.req_data[w_idx][gi];

      for (gr = 0; gr < N_REQ; gr++) begin : g_req
        assign bus.req_ready[gr][gi] = w_fire[gi] && (int'(w_idx) == gr);
      end
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int a = 0; a < N_ACC; a++) begin
        r_acc[a]  <= '0;
        r_pend[a] <= '0;
        r_cnt[a]  <= '0;
        r_ptr[a]  <= '0;
      end
    end else begin
      for (int a = 0; a < N_ACC; a++) begin
        // A write needs count==0 and retirement needs count==1, so the two
        // never target the same accumulator on the same edge.
        if (w_wr_hit[a]) begin
          r_acc[a] <= bus.wr_data;
        end else if (r_cnt[a] == CNT_ONE) begin
          r_acc[a] <= r_pend[a];
        end

        if (w_fire[a]) begin
          r_pend[a] <= w_sum[a];
          r_cnt[a]  <= CNT_LOAD;
          r_ptr[a]  <= (int'(w_grant_idx[a]) == N_REQ - 1) ? '0
                                                            : w_grant_idx[a] + PTR_W'(1);
        end else if (!w_cnt_zero[a]) begin
          r_cnt[a] <= r_cnt[a] - CNT_ONE;
        end
      end
    end
  end

  // Out-of-range selects read as zero and report not-ready.
  assign bus.wr_ready  = w_wr_sel_ok && w_cnt_zero[bus.wr_sel];
  assign bus.rd_data   = w_rd_sel_ok ? r_acc[bus.rd_sel] : '0;
  assign bus.all_ready = &w_cnt_le1;
  assign bus.idle      = &w_cnt_zero;
  assign bus.no_req    = ~|bus.req_valid;
endmodule

// File: tb/tb_accumulator_bank.sv
// -----------------------------------------------------------------------------
// tb_accumulator_bank
// Directed scenarios followed by randomized traffic. Expected outputs come from
// a timestamp-based reference model: each accumulator remembers the edge of its
// last dispatch and the sum that will land LATENCY edges later; readiness and
// retirement are derived from the age of that dispatch.
// -----------------------------------------------------------------------------
module tb_accumulator_bank;
  localparam int N_REQ = 4;
  localparam int N_ACC = 3;
  localparam int DW    = 32;
  localparam int LAT   = 6;

  logic clk = 1'b0;
  logic rst;

  accumulator_bank_if #(.N_REQ(N_REQ), .N_ACC(N_ACC), .DATA_WIDTH(DW)) bus ();

  accumulator_bank #(
    .N_REQ(N_REQ), .N_ACC(N_ACC), .DATA_WIDTH(DW), .LATENCY(LAT)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Stimulus for the next cycle.
  logic [N_REQ-1:0][N_ACC-1:0]         d_valid;
  logic [N_REQ-1:0][N_ACC-1:0][DW-1:0] d_data;
  logic                                d_wr_en;
  logic [1:0]                          d_wr_sel;
  logic [DW-1:0]                       d_wr_data;
  logic [1:0]                          d_rd_sel;
  logic                                d_reset;

  // Reference model.
  logic [DW-1:0] m_acc   [N_ACC];
  logic [DW-1:0] m_pend  [N_ACC];
  int            m_tdisp [N_ACC];
  int            m_ptr   [N_ACC];
  int            last_grant [N_ACC];
  int            now;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, now);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < N_ACC; a++) begin
      m_acc[a]   = '0;
      m_pend[a]  = '0;
      m_tdisp[a] = -1000;
      m_ptr[a]   = 0;
    end
  endtask

  task automatic clear_inputs();
    d_valid   = '0;
    d_data    = '0;
    d_wr_en   = 1'b0;
    d_wr_sel  = 2'd0;
    d_wr_data = '0;
    d_rd_sel  = 2'd0;
    d_reset   = 1'b0;
  endtask

  function automatic int winner(input int a);
    for (int o = 0; o < N_REQ; o++) begin
      if (d_valid[(m_ptr[a] + o) % N_REQ][a]) return (m_ptr[a] + o) % N_REQ;
    end
    return -1;
  endfunction

  // One clock cycle: drive, check combinational outputs, then advance the
  // model across the coming edge. Returns before that edge.
  task automatic step();
    logic [N_REQ-1:0][N_ACC-1:0] e_ready;
    bit  ok1, all_r, idle_e;
    bit  zero [N_ACC];
    bit  wrh  [N_ACC];
    bit  fire [N_ACC];
    int  w    [N_ACC];
    int  age;
    bit  retire;
    logic [DW-1:0] opa;

    @(negedge clk);
    rst           = d_reset;
    bus.req_valid = d_valid;
    bus.req_data  = d_data;
    bus.wr_en     = d_wr_en;
    bus.wr_sel    = d_wr_sel;
    bus.wr_data   = d_wr_data;
    bus.rd_sel    = d_rd_sel;
    #1;

    e_ready = '0;
    all_r   = 1'b1;
    idle_e  = 1'b1;
    for (int a = 0; a < N_ACC; a++) begin
      age     = now - m_tdisp[a];
      ok1     = (age >= LAT);
      zero[a] = (age >= LAT + 1);
      wrh[a]  = d_wr_en && (int'(d_wr_sel) == a) && zero[a];
      w[a]    = winner(a);
      fire[a] = (w[a] >= 0) && ok1 && !wrh[a];
      if (fire[a]) e_ready[w[a]][a] = 1'b1;
      last_grant[a] = fire[a] ? w[a] : -1;
      all_r  = all_r && ok1;
      idle_e = idle_e && zero[a];
    end

    chk("req_ready", 32'(bus.req_ready), 32'(e_ready));
    if (int'(d_wr_sel) < N_ACC) chk("wr_ready", 32'(bus.wr_ready), 32'(zero[d_wr_sel]));
    chk("rd_data", bus.rd_data, (int'(d_rd_sel) < N_ACC) ? m_acc[d_rd_sel] : 32'h0);
    chk("all_ready", 32'(bus.all_ready), 32'(all_r));
    chk("idle", 32'(bus.idle), 32'(idle_e));
    chk("no_req", 32'(bus.no_req), 32'(d_valid == '0));

    if (d_reset) begin
      model_reset();
      $display("edge %0d: reset", now);
    end else begin
      for (int a = 0; a < N_ACC; a++) begin
        age    = now - m_tdisp[a];
        retire = (age == LAT);
        opa    = retire ? m_pend[a] : m_acc[a];
        if (wrh[a]) begin
          m_acc[a] = d_wr_data;
          $display("edge %0d: write acc %0d <= %h", now, a, d_wr_data);
        end else if (retire) begin
          m_acc[a] = m_pend[a];
        end
        if (fire[a]) begin
          m_pend[a]  = opa + d_data[w[a]][a];
          m_tdisp[a] = now;
          m_ptr[a]   = (w[a] + 1) % N_REQ;
          $display("edge %0d: acc %0d grant req %0d addend %h -> %h",
                   now, a, w[a], d_data[w[a]][a], m_pend[a]);
        end
      end
    end
    now++;
  endtask

  initial begin
    int order[$];
    int gtime[$];

    now = 0;
    model_reset();
    clear_inputs();
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.wr_en     = 1'b0;
    bus.wr_sel    = '0;
    bus.wr_data   = '0;
    bus.rd_sel    = '0;
    repeat (2) @(posedge clk);

    // Reset state.
    step();
    chk("rst_idle", 32'(bus.idle), 32'd1);
    chk("rst_all_ready", 32'(bus.all_ready), 32'd1);
    chk("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
    chk("rst_rd_data", bus.rd_data, 32'd0);

    // Single add: requester 2 adds 5 to acc 0.
    clear_inputs();
    d_valid[2][0] = 1'b1;
    d_data[2][0]  = 32'd5;
    step();
    chk("grant_r2", 32'(bus.req_ready[2][0]), 32'd1);
    clear_inputs();
    for (int i = 1; i <= 7; i++) begin
      step();
      if (i <= 6) chk("busy_idle", 32'(bus.idle), 32'd0);
      if (i == 6) chk("no_rd_bypass", bus.rd_data, 32'd0);
      if (i == 7) chk("add5", bus.rd_data, 32'd5);
    end

    // Four requesters held valid to acc 1: back-to-back grants in order.
    clear_inputs();
    for (int r = 0; r < N_REQ; r++) begin
      d_valid[r][1] = 1'b1;
      d_data[r][1]  = DW'(1 << r);
    end
    d_rd_sel = 2'd1;
    for (int c = 0; c < 60 && order.size() < 4; c++) begin
      step();
      if (last_grant[1] >= 0) begin
        order.push_back(last_grant[1]);
        gtime.push_back(now);
        d_valid[last_grant[1]][1] = 1'b0;
      end
    end
    chk("grant_count", 32'(order.size()), 32'd4);
    for (int i = 0; i < order.size(); i++) begin
      chk("grant_order", 32'(order[i]), 32'(i));
      if (i > 0) chk("grant_gap", 32'(gtime[i] - gtime[i-1]), 32'(LAT));
    end
    clear_inputs();
    d_rd_sel = 2'd1;
    repeat (7) step();
    chk("sum15", bus.rd_data, 32'd15);

    // Fairness: pointer is back at 0 after requester 3, so 0 beats 3.
    d_valid[3][1] = 1'b1;
    d_valid[0][1] = 1'b1;
    step();
    chk("rr_fair_r0", 32'(bus.req_ready[0][1]), 32'd1);
    chk("rr_fair_r3", 32'(bus.req_ready[3][1]), 32'd0);
    clear_inputs();
    repeat (7) step();

    // Wrap-around and dropped write on a busy accumulator.
    d_wr_en   = 1'b1;
    d_wr_sel  = 2'd2;
    d_wr_data = 32'hFFFF_FFFF;
    step();
    chk("wr_ready_idle", 32'(bus.wr_ready), 32'd1);
    clear_inputs();
    d_valid[0][2] = 1'b1;
    d_data[0][2]  = 32'd2;
    step();
    chk("grant_wrap", 32'(bus.req_ready[0][2]), 32'd1);
    clear_inputs();
    d_wr_en   = 1'b1;
    d_wr_sel  = 2'd2;
    d_wr_data = 32'h0000_1234;
    d_rd_sel  = 2'd2;
    step();
    chk("wr_ready_busy", 32'(bus.wr_ready), 32'd0);
    clear_inputs();
    d_rd_sel = 2'd2;
    repeat (6) step();
    chk("wrap", bus.rd_data, 32'h0000_0001);

    // Reset three cycles after a dispatch discards the in-flight add.
    clear_inputs();
    d_valid[0][0] = 1'b1;
    d_data[0][0]  = 32'd7;
    step();
    clear_inputs();
    repeat (2) step();
    d_reset = 1'b1;
    step();
    d_reset = 1'b0;
    step();
    chk("rst_mid_idle", 32'(bus.idle), 32'd1);
    chk("rst_mid_acc0", bus.rd_data, 32'd0);
    repeat (5) begin
      step();
      chk("no_late_write", bus.rd_data, 32'd0);
    end

    // Randomized traffic.
    repeat (1500) begin
      d_reset = ($urandom_range(0, 99) == 0);
      for (int r = 0; r < N_REQ; r++) begin
        for (int a = 0; a < N_ACC; a++) begin
          d_valid[r][a] = ($urandom_range(0, 2) == 0);
          d_data[r][a]  = ($urandom_range(0, 3) == 0) ? $urandom : DW'($urandom_range(0, 255));
        end
      end
      d_wr_en   = ($urandom_range(0, 7) == 0);
      d_wr_sel  = 2'($urandom_range(0, 3));
      d_wr_data = $urandom;
      d_rd_sel  = 2'($urandom_range(0, 3));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
